// File: rtl/ofmap_output_controller.sv
// rtl/ofmap_output_controller.sv - drains one ofmap buffer bank and serializes each word into 16-bit elements
module ofmap_output_controller #(
  parameter int OC0             = 4,
  parameter int COUNTER_WID     = 16,
  parameter int CONFIG_WIDTH    = 32,
  parameter int BANK_ADDR_WIDTH = 32,
  parameter int READ_BANK_NUM   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       config_enable,
  input  logic [CONFIG_WIDTH-1:0]    config_data,
  output logic                       ren,
  output logic [BANK_ADDR_WIDTH-1:0] raddr,
  input  logic [16*OC0-1:0]          rdata,
  output logic [15:0]                output_dat,
  output logic                       output_vld,
  input  logic                       output_rdy,
  input  logic                       start_new_read_bank,
  input  logic                       ready_to_switch,
  output logic                       read_bank_done,
  output logic                       read_bank_ready_to_switch,
  output logic [COUNTER_WID-1:0]     read_bank_count
);

  localparam int WORD_W = 16 * OC0;
  localparam int CMP_W  = (CONFIG_WIDTH > BANK_ADDR_WIDTH) ? CONFIG_WIDTH : BANK_ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LOAD,
    S_SEND,
    S_DONE,
    S_WAIT
  } state_t;

  state_t                     state;
  logic [CONFIG_WIDTH-1:0]    words_per_bank;
  logic [BANK_ADDR_WIDTH-1:0] addr;
  logic [COUNTER_WID-1:0]     idx;
  logic [WORD_W-1:0]          shift_q;

  logic [CONFIG_WIDTH-1:0]    n_minus_1;
  logic [WORD_W-1:0]          shift_next;
  logic [COUNTER_WID-1:0]     count_next;
  logic                       last_elem;
  logic                       last_word;
  logic                       handshake;

  assign n_minus_1  = words_per_bank - CONFIG_WIDTH'(1);
  assign shift_next = shift_q >> 16;
  assign last_elem  = (idx == COUNTER_WID'(OC0 - 1));
  assign last_word  = (CMP_W'(addr) == CMP_W'(n_minus_1));
  assign handshake  = output_vld && output_rdy;
  assign count_next = (read_bank_count == COUNTER_WID'(READ_BANK_NUM)) ?
                      '0 : read_bank_count + COUNTER_WID'(1);

  // Outputs are registered: each branch sets the values seen in the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                     <= S_IDLE;
      words_per_bank            <= '0;
      addr                      <= '0;
      idx                       <= '0;
      shift_q                   <= '0;
      ren                       <= 1'b0;
      raddr                     <= '0;
      output_dat                <= '0;
      output_vld                <= 1'b0;
      read_bank_done            <= 1'b0;
      read_bank_ready_to_switch <= 1'b0;
      read_bank_count           <= '0;
    end else begin
      ren            <= 1'b0;
      read_bank_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (config_enable) begin
            words_per_bank <= config_data;
          end
          if (start_new_read_bank) begin
            addr <= '0;
            if (words_per_bank == '0) begin
              read_bank_done            <= 1'b1;
              read_bank_ready_to_switch <= 1'b1;
              read_bank_count           <= count_next;
              state                     <= S_DONE;
            end else begin
              ren   <= 1'b1;
              raddr <= '0;
              state <= S_READ;
            end
          end
        end
        S_READ: begin
          state <= S_LOAD;
        end
        S_LOAD: begin
          shift_q    <= rdata;
          output_dat <= rdata[15:0];
          output_vld <= 1'b1;
          idx        <= '0;
          state      <= S_SEND;
        end
        S_SEND: begin
          if (handshake) begin
            if (!last_elem) begin
              idx        <= idx + COUNTER_WID'(1);
              shift_q    <= shift_next;
              output_dat <= shift_next[15:0];
            end else begin
              output_vld <= 1'b0;
              if (!last_word) begin
                addr  <= addr + BANK_ADDR_WIDTH'(1);
                raddr <= addr + BANK_ADDR_WIDTH'(1);
                ren   <= 1'b1;
                state <= S_READ;
              end else begin
                read_bank_done            <= 1'b1;
                read_bank_ready_to_switch <= 1'b1;
                read_bank_count           <= count_next;
                state                     <= S_DONE;
              end
            end
          end
        end
        S_DONE: begin
          // An early switch request is honoured here so the FSM never waits for a second one.
          if (ready_to_switch) begin
            read_bank_ready_to_switch <= 1'b0;
            state                     <= S_IDLE;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (ready_to_switch) begin
            read_bank_ready_to_switch <= 1'b0;
            state                     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ofmap_output_controller.sv
// tb/tb_ofmap_output_controller.sv - directed bench for ofmap_output_controller
module tb_ofmap_output_controller;

  localparam int OC0 = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        config_enable;
  logic [31:0] config_data;
  logic        ren;
  logic [31:0] raddr;
  logic [63:0] rdata = '0;
  logic [15:0] output_dat;
  logic        output_vld;
  logic        output_rdy;
  logic        start_new_read_bank;
  logic        ready_to_switch;
  logic        read_bank_done;
  logic        read_bank_ready_to_switch;
  logic [15:0] read_bank_count;

  logic [63:0] mem [0:3];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Buffer model: registered read, data valid one cycle after ren.
  always @(posedge clk) if (ren) rdata <= mem[raddr[1:0]];

  ofmap_output_controller #(
    .OC0(OC0), .COUNTER_WID(16), .CONFIG_WIDTH(32), .BANK_ADDR_WIDTH(32), .READ_BANK_NUM(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .config_enable(config_enable), .config_data(config_data),
    .ren(ren), .raddr(raddr), .rdata(rdata),
    .output_dat(output_dat), .output_vld(output_vld), .output_rdy(output_rdy),
    .start_new_read_bank(start_new_read_bank), .ready_to_switch(ready_to_switch),
    .read_bank_done(read_bank_done), .read_bank_ready_to_switch(read_bank_ready_to_switch),
    .read_bank_count(read_bank_count)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic configure(input logic [31:0] n);
    config_enable = 1'b1;
    config_data   = n;
    tick();
    config_enable = 1'b0;
  endtask

  task automatic start_bank();
    start_new_read_bank = 1'b1;
    tick();
    start_new_read_bank = 1'b0;
  endtask

  initial begin
    logic [15:0] elems[$];
    logic [31:0] raddrs[$];
    logic [15:0] xval;
    logic        prev_vld;
    logic        prev_rdy;
    logic [15:0] prev_dat;
    logic        done_seen;

    mem[0] = 64'h0004_0003_0002_0001;
    mem[1] = 64'h0008_0007_0006_0005;
    mem[2] = 64'h000c_000b_000a_0009;
    mem[3] = 64'h0;
    xval   = 'x;

    rst_n = 1'b0; config_enable = 1'b0; config_data = '0; output_rdy = 1'b1;
    start_new_read_bank = 1'b0; ready_to_switch = 1'b0;
    tick(); tick();
    check("rst_ren", ren, 0);
    check("rst_raddr", raddr, 0);
    check("rst_vld", output_vld, 0);
    check("rst_dat", output_dat, 0);
    check("rst_done", read_bank_done, 0);
    check("rst_rts", read_bank_ready_to_switch, 0);
    check("rst_count", read_bank_count, 0);
    rst_n = 1'b1;
    tick();

    // Single word bank, continuous ready.
    configure(1);
    start_bank();
    check("t1_ren", ren, 1);
    check("t1_raddr", raddr, 0);
    check("t1_vld_read", output_vld, 0);
    tick();
    check("t1_ren_load", ren, 0);
    check("t1_vld_load", output_vld, 0);
    for (int e = 0; e < OC0; e++) begin
      tick();
      check("t1_vld", output_vld, 1);
      check("t1_dat", output_dat, 64'(e + 1));
      check("t1_done_early", read_bank_done, 0);
    end
    tick();
    check("t1_vld_end", output_vld, 0);
    check("t1_done", read_bank_done, 1);
    check("t1_rts", read_bank_ready_to_switch, 1);
    check("t1_count", read_bank_count, 1);
    tick();
    check("t1_done_pulse", read_bank_done, 0);
    check("t1_rts_hold", read_bank_ready_to_switch, 1);
    ready_to_switch = 1'b1;
    tick();
    ready_to_switch = 1'b0;
    check("t1_rts_clr", read_bank_ready_to_switch, 0);

    // Three words with ready toggling every cycle.
    configure(3);
    start_bank();
    prev_vld = 1'b0; prev_rdy = 1'b0; prev_dat = '0; done_seen = 1'b0;
    for (int k = 0; k < 200 && !done_seen; k++) begin
      if (ren) raddrs.push_back(raddr);
      if (prev_vld && !prev_rdy) begin
        check("t2_hold_vld", output_vld, 1);
        check("t2_hold_dat", output_dat, prev_dat);
      end
      if (read_bank_done) done_seen = 1'b1;
      output_rdy = (k % 2 == 0);
      if (output_vld && output_rdy) elems.push_back(output_dat);
      prev_vld = output_vld; prev_rdy = output_rdy; prev_dat = output_dat;
      tick();
    end
    output_rdy = 1'b1;
    check("t2_done_seen", done_seen, 1);
    check("t2_n_elems", elems.size(), 12);
    for (int i = 0; i < 12; i++)
      check("t2_elem", (i < elems.size()) ? elems[i] : xval, 64'(i + 1));
    check("t2_n_raddr", raddrs.size(), 3);
    for (int i = 0; i < 3; i++)
      check("t2_raddr", (i < raddrs.size()) ? raddrs[i] : 32'hffff_ffff, 64'(i));
    check("t2_count_wrap", read_bank_count, 0);
    check("t2_rts", read_bank_ready_to_switch, 1);
    ready_to_switch = 1'b1;
    tick();
    ready_to_switch = 1'b0;
    check("t2_rts_clr", read_bank_ready_to_switch, 0);

    // Zero-length bank.
    configure(0);
    start_bank();
    check("t3_done", read_bank_done, 1);
    check("t3_rts", read_bank_ready_to_switch, 1);
    check("t3_ren", ren, 0);
    check("t3_vld", output_vld, 0);
    check("t3_count", read_bank_count, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t3_done_pulse", read_bank_done, 0);
      check("t3_rts_hold", read_bank_ready_to_switch, 1);
      check("t3_ren_idle", ren, 0);
      check("t3_vld_idle", output_vld, 0);
    end
    ready_to_switch = 1'b1;
    tick();
    ready_to_switch = 1'b0;
    check("t3_rts_clr", read_bank_ready_to_switch, 0);

    // Start and config during SEND are ignored; early switch request during DONE.
    configure(1);
    output_rdy = 1'b0;
    start_bank();
    tick();
    tick();
    check("t4_vld", output_vld, 1);
    check("t4_dat0", output_dat, 1);
    start_new_read_bank = 1'b1; config_enable = 1'b1; config_data = 5;
    tick();
    start_new_read_bank = 1'b0; config_enable = 1'b0;
    check("t4_hold_vld", output_vld, 1);
    check("t4_hold_dat", output_dat, 1);
    output_rdy = 1'b1;
    for (int e = 1; e < OC0; e++) begin
      tick();
      check("t4_dat", output_dat, 64'(e + 1));
    end
    tick();
    check("t4_done", read_bank_done, 1);
    check("t4_count_wrap", read_bank_count, 0);
    ready_to_switch = 1'b1;
    tick();
    ready_to_switch = 1'b0;
    check("t4_rts_early_clr", read_bank_ready_to_switch, 0);
    check("t4_done_pulse", read_bank_done, 0);
    tick();
    check("t4_no_restart", ren, 0);
    tick();
    check("t4_no_restart2", ren, 0);
    start_bank();
    check("t4b_ren", ren, 1);
    check("t4b_raddr", raddr, 0);
    for (int k = 0; k < 1 + OC0; k++) tick();
    check("t4b_dat_last", output_dat, 4);
    tick();
    check("t4b_done_n_kept", read_bank_done, 1);
    check("t4b_ren_none", ren, 0);
    check("t4b_count", read_bank_count, 1);
    ready_to_switch = 1'b1;
    tick();
    ready_to_switch = 1'b0;

    // Reset after two of four elements, then restart.
    configure(1);
    start_bank();
    tick();
    tick();
    check("t5_dat0", output_dat, 1);
    tick();
    check("t5_dat1", output_dat, 2);
    tick();
    check("t5_dat2", output_dat, 3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t5_vld", output_vld, 0);
    check("t5_dat", output_dat, 0);
    check("t5_ren", ren, 0);
    check("t5_raddr", raddr, 0);
    check("t5_done", read_bank_done, 0);
    check("t5_rts", read_bank_ready_to_switch, 0);
    check("t5_count", read_bank_count, 0);
    tick();
    check("t5_done_after", read_bank_done, 0);
    configure(1);
    start_bank();
    check("t5_re_ren", ren, 1);
    check("t5_re_raddr", raddr, 0);
    tick();
    tick();
    check("t5_re_vld", output_vld, 1);
    check("t5_re_dat0", output_dat, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ofmap_output_controller.md
Name: ofmap_output_controller

Overview:
- Drain side of the ofmap double buffer. Reads one bank of 16*OC0-bit words through the buffer's read port and serializes each word into OC0 16-bit elements on a valid/ready output stream.
- Handshakes with the main FSM, mirroring the input controllers' write-bank protocol: bank start, bank-done pulse, ready-to-switch level, and a bank counter.

Parameters:
- OC0, 4, elements per buffer word; word width is 16*OC0.
- COUNTER_WID, 16, width of the element index and bank counter.
- CONFIG_WIDTH, 32, width of config_data.
- BANK_ADDR_WIDTH, 32, width of raddr.
- READ_BANK_NUM, 1, bank counter counts 0..READ_BANK_NUM, then wraps to 0.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- config_enable  in  1  load config_data as words-per-bank (N); honoured only in IDLE
- config_data  in  CONFIG_WIDTH  words per bank
- ren  out  1  buffer read enable
- raddr  out  BANK_ADDR_WIDTH  buffer read address
- rdata  in  16*OC0  buffer read data, valid exactly 1 cycle after ren
- output_dat  out  16  serialized element
- output_vld  out  1  output_dat valid
- output_rdy  in  1  downstream accepts
- start_new_read_bank  in  1  main FSM: begin draining the read bank
- ready_to_switch  in  1  main FSM: banks are switching
- read_bank_done  out  1  one-cycle pulse after the last element is accepted
- read_bank_ready_to_switch  out  1  level, set with read_bank_done, cleared by ready_to_switch
- read_bank_count  out  COUNTER_WID  completed banks

Behaviour:
- Reset:
  - state=IDLE; N=0; addr=0; idx=0; shift register=0.
  - ren=0, raddr=0, output_vld=0, output_dat=0.
  - read_bank_done=0, read_bank_ready_to_switch=0, read_bank_count=0.
  - Reset mid-operation aborts the bank; no done pulse is produced.
- States: IDLE, READ, LOAD, SEND, DONE, WAIT.
- IDLE:
  - config_enable loads N.
  - start_new_read_bank goes to READ with addr=0; if N==0, goes to DONE instead.
  - config_enable in any other state is ignored.
  - start_new_read_bank outside IDLE is ignored.
- READ: ren=1 and raddr=addr for exactly one cycle, then LOAD. ren is 0 in every other state.
- LOAD: captures rdata into the shift register, sets idx=0, goes to SEND.
- SEND:
  - output_vld=1; output_dat = element idx of the captured word, where element 0 = rdata[15:0] and element k = rdata[16k+15:16k].
  - Without output_rdy, output_dat and output_vld hold stable.
  - On handshake (vld&&rdy) with idx<OC0-1: idx++ and stay in SEND.
  - On handshake with idx==OC0-1 and addr<N-1: addr++ and go to READ.
  - On handshake with idx==OC0-1 and addr==N-1: go to DONE.
  - output_vld falls the cycle after the last handshake of each word.
- Latency:
  - start_new_read_bank sampled in cycle t: ren in t+1, output_vld in t+3.
  - Between words there is a 2-cycle bubble (READ, LOAD) with output_vld=0.
  - One bank occupies at least 3 + N*(OC0+2) - 2 cycles from start to DONE.
- DONE (1 cycle):
  - read_bank_done=1 for one cycle.
  - read_bank_ready_to_switch is set in the same cycle.
  - read_bank_count increments, wrapping READ_BANK_NUM to 0.
  - Then goes to WAIT.
- WAIT:
  - Holds until ready_to_switch, then goes to IDLE and clears read_bank_ready_to_switch the next cycle.
  - If ready_to_switch is already high in DONE, the level is still set for the DONE cycle and cleared on the following edge.
- ready_to_switch in any state other than WAIT and DONE is ignored.
- Address arithmetic: addr is BANK_ADDR_WIDTH wide; comparison uses N-1 computed in CONFIG_WIDTH. N must be ≤ 2^BANK_ADDR_WIDTH.

Test Plan:
- OC0=4, N=1, rdata@addr0=0x0004_0003_0002_0001, output_rdy=1:
  - ren one cycle, raddr=0; output_dat 1,2,3,4 on four consecutive cycles starting t+3.
  - read_bank_done pulses once; read_bank_count=1.
- N=3, output_rdy toggled 1/0 each cycle:
  - 12 elements delivered in address/element order with no drops or duplicates.
  - output_dat stable while rdy=0; raddr sequence 0,1,2.
- Zero-length bank:
  - N=0 then start_new_read_bank: no ren, no output_vld.
  - read_bank_done pulses in the cycle after start; read_bank_ready_to_switch=1 until ready_to_switch.
- Bank protocol and counter wrap:
  - Two banks with READ_BANK_NUM=1: read_bank_count 0→1→0.
  - start_new_read_bank asserted during SEND is ignored; config_enable during SEND leaves N unchanged.
- Reset mid-SEND (after 2 of 4 elements):
  - Next cycle all outputs are 0 and state is IDLE; no read_bank_done.
  - Restarted bank begins again from raddr=0, element 0.
